// File: rtl/loopback_pkg.sv
// Shared types and status-word layout for the loopback receive error controller.
package loopback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam int STATE_MSB     = 31;
    localparam int STATE_LSB     = 30;
    localparam int LOCK_FAIL_BIT = 29;
    localparam int SAT_BIT       = 28;
    localparam int CNT_W_DEF     = 28;

endpackage

// File: rtl/loopback_rx_err_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky flag that records
// any increment attempted while already at full scale.
module sat_counter #(
    parameter int W = 28
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt_next,
    output logic         ovf_next
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;
    logic [W:0]   inc_res;

    // Result is {increment_blocked, new_value}.
    function automatic logic [W:0] sat_inc(input logic [W-1:0] v);
        if (&v) return {1'b1, v};
        return {1'b0, v + W'(1)};
    endfunction

    always_comb begin
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        inc_res = sat_inc(cnt_q);
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            cnt_d = inc_res[W-1:0];
            ovf_d = ovf_q | inc_res[W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_next = cnt_d;
    assign ovf_next = ovf_d;

endmodule

// File: rtl/loopback_rx_err_ctrl.sv
// Sequences one loopback error-measurement run (arm on lock, count over a window)
// and publishes state, flags and error count as a packed 32-bit status word.
module loopback_rx_err_ctrl
    import loopback_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int WIN_W        = 32,
    parameter int LOCK_HOLD    = 16,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic             user_clk,
    input  logic             user_rst_n,
    input  logic             ctrl_start,
    input  logic [WIN_W-1:0] ctrl_window,
    input  logic             rx_valid,
    input  logic             rx_err,
    input  logic             rx_lock,
    output logic [31:0]      reg_data_out,
    output logic             busy,
    output logic             done_pulse
);

    localparam int HOLD_W = $clog2(LOCK_HOLD + 1);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic               start_dly_q;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               lock_fail_q, lock_fail_d;
    logic               err_clr, err_inc;
    logic [CNT_W-1:0]   err_cnt_d;
    logic               sat_d;
    logic [31:0]        reg_data_q, reg_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               start_edge;

    assign start_edge = ctrl_start & ~start_dly_q;

    always_comb begin
        state_d     = state_q;
        win_cnt_d   = win_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        lock_fail_d = lock_fail_q;
        err_clr     = 1'b0;
        err_inc     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_edge) begin
                    err_clr     = 1'b1;
                    lock_fail_d = 1'b0;
                    win_cnt_d   = ctrl_window;
                    hold_cnt_d  = '0;
                    tmo_cnt_d   = '0;
                    state_d     = ST_ARM;
                end
            end
            ST_ARM: begin
                tmo_cnt_d  = tmo_cnt_q + TMO_W'(1);
                hold_cnt_d = rx_lock ? hold_cnt_q + HOLD_W'(1) : '0;
                // Lock qualification beats the timeout when both land together.
                if (rx_lock && hold_cnt_q == HOLD_W'(LOCK_HOLD - 1)) begin
                    state_d = ST_RUN;
                end else if (tmo_cnt_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
                    lock_fail_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_RUN: begin
                if (win_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else if (rx_valid) begin
                    win_cnt_d = win_cnt_q - WIN_W'(1);
                    err_inc   = rx_err;
                    if (win_cnt_q == WIN_W'(1)) state_d = ST_DONE;
                end
                // A lock drop still counts this cycle's word but ends the run.
                if (!rx_lock) begin
                    lock_fail_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            default: ;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk      (user_clk),
        .rst_n    (user_rst_n),
        .clr      (err_clr),
        .inc      (err_inc),
        .cnt_next (err_cnt_d),
        .ovf_next (sat_d)
    );

    always_comb begin
        reg_data_d                     = '0;
        reg_data_d[STATE_MSB:STATE_LSB] = state_d;
        reg_data_d[LOCK_FAIL_BIT]      = lock_fail_d;
        reg_data_d[SAT_BIT]            = sat_d;
        reg_data_d[CNT_W-1:0]          = err_cnt_d;
        busy_d = (state_d == ST_ARM) || (state_d == ST_RUN);
        done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q     <= ST_IDLE;
            start_dly_q <= 1'b0;
            win_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            lock_fail_q <= 1'b0;
            reg_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_dly_q <= ctrl_start;
            win_cnt_q   <= win_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            lock_fail_q <= lock_fail_d;
            reg_data_q  <= reg_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign reg_data_out = reg_data_q;
    assign busy         = busy_q;
    assign done_pulse   = done_q;

endmodule

// File: tb/tb_loopback_rx_err_ctrl.sv
// Directed bench: a table of complete runs plus hand-written corner sequences,
// on a 28-bit-count instance and a 4-bit-count instance sharing the same inputs.
module tb_loopback_rx_err_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ctrl_start;
    logic [31:0] ctrl_window;
    logic        rx_valid, rx_err, rx_lock;
    logic [31:0] reg_m, reg_s;
    logic        busy_m, busy_s, done_m, done_s;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    loopback_rx_err_ctrl #(.CNT_W(28), .WIN_W(32), .LOCK_HOLD(16), .LOCK_TIMEOUT(64)) dut_m (
        .user_clk(clk), .user_rst_n(rst_n), .ctrl_start(ctrl_start), .ctrl_window(ctrl_window),
        .rx_valid(rx_valid), .rx_err(rx_err), .rx_lock(rx_lock),
        .reg_data_out(reg_m), .busy(busy_m), .done_pulse(done_m)
    );

    loopback_rx_err_ctrl #(.CNT_W(4), .WIN_W(32), .LOCK_HOLD(16), .LOCK_TIMEOUT(64)) dut_s (
        .user_clk(clk), .user_rst_n(rst_n), .ctrl_start(ctrl_start), .ctrl_window(ctrl_window),
        .rx_valid(rx_valid), .rx_err(rx_err), .rx_lock(rx_lock),
        .reg_data_out(reg_s), .busy(busy_s), .done_pulse(done_s)
    );

    typedef struct {
        string       name;
        int          window;
        bit          lock;
        int          err_mode;   // 0 none, 1 words 3/50/100, 2 every word
        int          drop_word;  // word index carrying rx_lock=0, 0 = never
        int          exp_arm;
        logic [31:0] exp_m;
        logic [31:0] exp_s;
    } run_vec_t;

    run_vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
        if (done_m) done_cnt++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic bit err_of(input int mode, input int w);
        if (mode == 1) return (w == 3 || w == 50 || w == 100);
        if (mode == 2) return 1'b1;
        return 1'b0;
    endfunction

    task automatic start_run(input string nm, input logic [31:0] w);
        ctrl_start = 1'b0;
        step();
        ctrl_start  = 1'b1;
        ctrl_window = w;
        step();
        chk({nm, "_arm_entry"}, reg_m, 32'h4000_0000);
        chk({nm, "_busy"}, {31'b0, busy_m}, 32'd1);
        done_cnt = 0;
    endtask

    task automatic wait_arm_exit(output int n);
        n = 0;
        while (reg_m[31:30] == 2'b01 && n < 300) begin
            step();
            n++;
        end
    endtask

    task automatic do_run(input run_vec_t v);
        int arm_n;
        int w;
        rx_lock  = v.lock;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        start_run(v.name, v.window);
        wait_arm_exit(arm_n);
        chk({v.name, "_arm_cycles"}, 32'(arm_n), 32'(v.exp_arm));
        w = 0;
        while (reg_m[31:30] == 2'b10 && w < v.window + 4) begin
            w++;
            rx_valid = 1'b1;
            rx_err   = err_of(v.err_mode, w);
            if (w == v.drop_word) rx_lock = 1'b0;
            step();
        end
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        // ctrl_start is still high here: the held level must not retrigger.
        step();
        step();
        chk({v.name, "_reg_m"}, reg_m, v.exp_m);
        chk({v.name, "_reg_s"}, reg_s, v.exp_s);
        chk({v.name, "_busy_end"}, {31'b0, busy_m}, 32'd0);
        chk({v.name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        int n;
        bit saw_run;

        vecs[0] = '{"normal",   100, 1'b1, 1, 0,  16, 32'hC000_0003, 32'hC000_0003};
        vecs[1] = '{"timeout",  100, 1'b0, 0, 0,  64, 32'hE000_0000, 32'hE000_0000};
        vecs[2] = '{"saturate",  40, 1'b1, 2, 0,  16, 32'hC000_0028, 32'hD000_000F};
        vecs[3] = '{"lockdrop", 100, 1'b1, 2, 20, 16, 32'hE000_0014, 32'hF000_000F};
        vecs[4] = '{"win0",       0, 1'b1, 2, 0,  16, 32'hC000_0000, 32'hC000_0000};
        vecs[5] = '{"win1",       1, 1'b1, 2, 0,  16, 32'hC000_0001, 32'hC000_0001};

        rst_n       = 1'b0;
        ctrl_start  = 1'b0;
        ctrl_window = '0;
        rx_valid    = 1'b0;
        rx_err      = 1'b0;
        rx_lock     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("reset_reg_m", reg_m, 32'h0);
        chk("reset_reg_s", reg_s, 32'h0);
        chk("reset_busy", {31'b0, busy_m}, 32'd0);
        chk("reset_done", {31'b0, done_m}, 32'd0);

        // Each run after the first starts from DONE, so start_run's ARM check
        // also confirms that a new edge in DONE clears the previous result.
        for (int i = 0; i < 6; i++) do_run(vecs[i]);

        // Lock toggling every 8 cycles never accumulates 16 consecutive lock cycles.
        rx_lock = 1'b0;
        start_run("toggle", 32'd10);
        n = 0;
        saw_run = 1'b0;
        while (reg_m[31:30] == 2'b01 && n < 300) begin
            rx_lock = ((n / 8) % 2) == 1;
            step();
            n++;
            if (reg_m[31:30] == 2'b10) saw_run = 1'b1;
        end
        chk("toggle_no_run", {31'b0, saw_run}, 32'd0);
        chk("toggle_cycles", 32'(n), 32'd64);
        chk("toggle_reg", reg_m, 32'hE000_0000);

        // Start edge inside RUN is ignored and does not clear the count.
        rx_lock = 1'b1;
        start_run("midstart", 32'd10);
        wait_arm_exit(n);
        for (int w = 1; w <= 5; w++) begin
            rx_valid = 1'b1;
            rx_err   = 1'b1;
            if (w == 2) ctrl_start = 1'b0;
            if (w == 3) ctrl_start = 1'b1;
            step();
        end
        chk("midstart_run5", reg_m, 32'h8000_0005);
        for (int w = 6; w <= 10; w++) step();
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        step();
        chk("midstart_final", reg_m, 32'hC000_000A);

        // Asynchronous reset in the middle of RUN.
        start_run("rstmid", 32'd50);
        wait_arm_exit(n);
        for (int w = 1; w <= 5; w++) begin
            rx_valid = 1'b1;
            rx_err   = 1'b1;
            step();
        end
        chk("rstmid_pre", reg_m, 32'h8000_0005);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_reg_m", reg_m, 32'h0);
        chk("rstmid_reg_s", reg_s, 32'h0);
        chk("rstmid_busy", {31'b0, busy_m}, 32'd0);
        chk("rstmid_done", {31'b0, done_m}, 32'd0);
        ctrl_start = 1'b0;
        rx_valid   = 1'b0;
        rx_err     = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("rstmid_idle", reg_m, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
